canvas_store: RTL

Canvas memory at the far end of the brush plot interface. It accepts the same plot stream the paint datapath drives into the VGA adapter (x, y, colour, plot) and stores it in a 160x120, 3-bit shadow canvas. It then reads the canvas back as a raster-order pixel stream with a valid/ready handshake, for screen dump and replay. It sits beside the VGA adapter on the brush outputs.

---
 rtl/canvas_store_if.sv | 25 ++
 rtl/canvas_store.sv | 105 ++++++++++
 2 files changed

// File: rtl/canvas_store_if.sv
// canvas_store_if: brush plot stream in, raster pixel stream out
`timescale 1ns/1ps
interface canvas_store_if;
  logic       plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot_ready;
  logic       rd_start;
  logic       rd_busy;
  logic       px_valid;
  logic       px_ready;
  logic [7:0] px_x;
  logic [6:0] px_y;
  logic [2:0] px_colour;
  logic       px_last;
  modport master (
    output plot, x, y, colour, rd_start, px_ready,
    input  plot_ready, rd_busy, px_valid, px_x, px_y, px_colour, px_last
  );
  modport slave (
    input  plot, x, y, colour, rd_start, px_ready,
    output plot_ready, rd_busy, px_valid, px_x, px_y, px_colour, px_last
  );
endinterface

// File: rtl/canvas_store.sv
// canvas_store: 160x120x3 shadow canvas written by the plot stream and read back in raster order.
// Defining CANVAS_CLEAR_EN adds clear_req and a clear-to-black pass (also run after reset).
`timescale 1ns/1ps
module canvas_store #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 120
) (
  input logic clk,
  input logic resetn,
`ifdef CANVAS_CLEAR_EN
  input logic clear_req,
`endif
  canvas_store_if.slave b
);
  localparam int N = WIDTH * HEIGHT;
  localparam logic [7:0] XM = 8'(WIDTH - 1);
  localparam logic [6:0] YM = 7'(HEIGHT - 1);
`ifdef CANVAS_CLEAR_EN
  typedef enum logic [1:0] {IDLE, FETCH, DATA, CLEAR} state_t;
  localparam logic [14:0] CE = 15'(N - 1);
  logic [14:0] ca;
  logic        init;
`else
  typedef enum logic [1:0] {IDLE, FETCH, DATA} state_t;
`endif
  state_t      state;
  logic [2:0]  mem [N];
  logic        acc, we;
  logic [14:0] wa, ra, waddr;
  logic [2:0]  wdata;
  assign acc = b.plot && b.plot_ready;
  assign wa  = {1'b0, b.y, 7'b0} + {3'b0, b.y, 5'b0} + {7'b0, b.x};
  assign ra  = {1'b0, b.px_y, 7'b0} + {3'b0, b.px_y, 5'b0} + {7'b0, b.px_x};
`ifdef CANVAS_CLEAR_EN
  assign we    = state == CLEAR || (acc && b.x <= XM && b.y <= YM);
  assign waddr = state == CLEAR ? ca : wa;
  assign wdata = state == CLEAR ? 3'b000 : b.colour;
`else
  assign we    = acc && b.x <= XM && b.y <= YM;
  assign waddr = wa;
  assign wdata = b.colour;
`endif
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // px_colour is the RAM output register; nothing reads the RAM while DATA holds it
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state        <= IDLE;
      b.plot_ready <= 1'b0;
      b.rd_busy    <= 1'b0;
      b.px_valid   <= 1'b0;
      b.px_last    <= 1'b0;
      b.px_x       <= '0;
      b.px_y       <= '0;
      b.px_colour  <= '0;
`ifdef CANVAS_CLEAR_EN
      ca           <= '0;
      init         <= 1'b0;
`endif
    end else begin
      b.plot_ready <= 1'b1;
      case (state)
        IDLE:
`ifdef CANVAS_CLEAR_EN
          if (clear_req || !init) begin
            state        <= CLEAR;
            ca           <= '0;
            init         <= 1'b1;
            b.plot_ready <= 1'b0;
          end else
`endif
          if (b.rd_start) begin
            state     <= FETCH;
            b.rd_busy <= 1'b1;
            b.px_x    <= '0;
            b.px_y    <= '0;
          end
        FETCH:
          if (!acc) begin
            state       <= DATA;
            b.px_valid  <= 1'b1;
            b.px_colour <= mem[ra];
            b.px_last   <= b.px_x == XM && b.px_y == YM;
          end
        DATA:
          if (b.px_ready) begin
            state      <= b.px_last ? IDLE : FETCH;
            b.rd_busy  <= !b.px_last;
            b.px_valid <= 1'b0;
            b.px_last  <= 1'b0;
            b.px_x     <= b.px_x == XM ? '0 : b.px_x + 1'b1;
            b.px_y     <= b.px_y + 7'(b.px_x == XM);
          end
`ifdef CANVAS_CLEAR_EN
        CLEAR:
          if (ca == CE) state <= IDLE;
          else begin
            ca           <= ca + 1'b1;
            b.plot_ready <= 1'b0;
          end
`endif
        default: state <= IDLE;
      endcase
    end
endmodule
